// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe turn sequencer.
// Board cell i lives in bits [2i+1:2i] of the packed 18-bit board word.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10
    } cell_t;

    typedef enum logic [2:0] {
        CLEAR,
        CLR_WAIT,
        WAIT,
        CHECK,
        WRITE,
        SETTLE,
        EVAL,
        DONE
    } ctrl_state_t;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    // Rows, columns, then the two diagonals.
    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Out-of-range indices read as EMPTY so callers never slice past the board.
    function automatic cell_t cell_at(input logic [2*NUM_CELLS-1:0] board,
                                      input logic [3:0]             idx);
        cell_t c;
        c = EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == 4'(i)) c = cell_t'(board[2*i +: 2]);
        end
        return c;
    endfunction

endpackage

// File: rtl/win_detect.sv
// Combinational line check: asserts win when the given player owns any
// complete row, column or diagonal of the board.
module win_detect
    import tictactoe_pkg::*;
(
    input  logic [2*NUM_CELLS-1:0] board,
    input  cell_t                  player,
    output logic                   win
);

    logic [NUM_LINES-1:0] line_hit;

    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        assign line_hit[l] = (cell_at(board, WIN_LINES[l][0]) == player) &&
                             (cell_at(board, WIN_LINES[l][1]) == player) &&
                             (cell_at(board, WIN_LINES[l][2]) == player);
    end

    assign win = (player != EMPTY) && (|line_hit);

endmodule

// File: rtl/turn_ctrl.sv
// Tic-tac-toe game sequencer: clears the board memory, grants X/O moves
// alternately, rejects illegal moves, writes legal ones and detects win/draw.
module turn_ctrl
    import tictactoe_pkg::*;
#(
    parameter bit FIRST_O = 1'b0,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 0
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        new_game,
    input  logic        x_req,
    input  logic [3:0]  x_addr,
    input  logic        o_req,
    input  logic [3:0]  o_addr,
    output logic        x_ack,
    output logic        o_ack,
    output logic        x_rej,
    output logic        o_rej,
    output logic [3:0]  mem_addr,
    output logic [1:0]  mem_state,
    output logic        mem_we,
    input  logic [17:0] gBoard,
    output logic        turn,
    output logic        game_over,
    output logic [1:0]  winner
);

    localparam logic [3:0]  CLR_LAST = 4'(NUM_CELLS - 1);
    localparam logic [3:0]  LAT_LAST = 4'(MEM_LAT - 1);
    localparam logic [3:0]  MAX_MOVES = 4'(NUM_CELLS);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam bit          TMO_EN   = (TIMEOUT != 0);

    ctrl_state_t state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [3:0]  move_cnt, move_cnt_n;
    logic [3:0]  addr_q, addr_q_n;
    logic [15:0] timer, timer_n;
    logic        turn_n, game_over_n;
    cell_t       winner_q, winner_n;

    cell_t       mover;
    logic        cur_req;
    logic [3:0]  cur_addr;
    logic        illegal;
    logic        mover_wins;

    assign mover    = turn ? O : X;
    assign cur_req  = turn ? o_req  : x_req;
    assign cur_addr = turn ? o_addr : x_addr;
    assign illegal  = (addr_q >= 4'(NUM_CELLS)) || (cell_at(gBoard, addr_q) != EMPTY);
    assign winner   = winner_q;

    win_detect u_win (
        .board  (gBoard),
        .player (mover),
        .win    (mover_wins)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        move_cnt_n  = move_cnt;
        addr_q_n    = addr_q;
        timer_n     = timer;
        turn_n      = turn;
        game_over_n = game_over;
        winner_n    = winner_q;

        case (state)
            CLEAR: begin
                if (cnt == CLR_LAST) begin
                    state_n = CLR_WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            CLR_WAIT: begin
                if (cnt == LAT_LAST) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            WAIT: begin
                // The idle player's request is never looked at here, so it stays pending.
                if (cur_req) begin
                    addr_q_n = cur_addr;
                    state_n  = CHECK;
                end else if (TMO_EN) begin
                    if (timer == TMO_LAST) begin
                        state_n     = DONE;
                        game_over_n = 1'b1;
                        winner_n    = turn ? X : O;
                    end else begin
                        timer_n = timer + 16'd1;
                    end
                end
            end
            CHECK: begin
                if (illegal) begin
                    state_n = WAIT;
                    timer_n = '0;
                end else begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                move_cnt_n = move_cnt + 4'd1;
                timer_n    = '0;
                cnt_n      = '0;
                state_n    = SETTLE;
            end
            SETTLE: begin
                if (cnt == LAT_LAST) begin
                    state_n = EVAL;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            EVAL: begin
                if (mover_wins) begin
                    winner_n    = mover;
                    game_over_n = 1'b1;
                    state_n     = DONE;
                end else if (move_cnt == MAX_MOVES) begin
                    winner_n    = EMPTY;
                    game_over_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    turn_n  = ~turn;
                    timer_n = '0;
                    state_n = WAIT;
                end
            end
            DONE: ;
            default: state_n = CLEAR;
        endcase

        // A restart wins over whatever the current state decided.
        if (new_game) begin
            state_n     = CLEAR;
            cnt_n       = '0;
            move_cnt_n  = '0;
            timer_n     = '0;
            turn_n      = FIRST_O;
            game_over_n = 1'b0;
            winner_n    = EMPTY;
        end
    end

    always_ff @(posedge ph1) begin
        if (!reset) begin
            state     <= CLEAR;
            cnt       <= '0;
            move_cnt  <= '0;
            addr_q    <= '0;
            timer     <= '0;
            turn      <= FIRST_O;
            game_over <= 1'b0;
            winner_q  <= EMPTY;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            move_cnt  <= move_cnt_n;
            addr_q    <= addr_q_n;
            timer     <= timer_n;
            turn      <= turn_n;
            game_over <= game_over_n;
            winner_q  <= winner_n;
        end
    end

    // Strobes are gated by reset so nothing reaches the memory while reset is held.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_state = EMPTY;
        x_ack     = 1'b0;
        o_ack     = 1'b0;
        x_rej     = 1'b0;
        o_rej     = 1'b0;
        if (reset) begin
            case (state)
                CLEAR: begin
                    mem_we   = 1'b1;
                    mem_addr = cnt;
                end
                WRITE: begin
                    mem_we    = 1'b1;
                    mem_addr  = addr_q;
                    mem_state = mover;
                    x_ack     = ~turn;
                    o_ack     = turn;
                end
                CHECK: begin
                    x_rej = illegal & ~turn;
                    o_rej = illegal & turn;
                end
                default: ;
            endcase
        end
    end

endmodule
